load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 1024, number of 32-bit words in the attached data memory; legal word indices are 0..MEM_WORDS-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  unit can accept a request; SHALL equal (state==IDLE).
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RISC-V size code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; low byte/halfword used for SB/SH.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-012 resp_err  output  1  access rejected, valid with resp_valid.
REQ-013 mem_addr  output  32  word index to data memory, equal to req_addr[31:2].
REQ-014 mem_wdata  output  32  write data to data memory.
REQ-015 mem_we  output  1  memory write enable; memory writes at the clk edge that ends a cycle with mem_we=1.
REQ-016 mem_rdata  input  32  combinational memory read data; valid when mem_we=0.

Function
REQ-017 FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.
REQ-018 Request handshake: a request is accepted at the edge where req_valid=1 and req_ready=1. All request fields SHALL be registered at that edge; later input changes SHALL NOT affect the operation.
REQ-019 Error check at accept. resp_err=1 when any of the following holds:
- illegal funct3 (load 011/11x; store 011/1xx);
- misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0;
- addr[31:2] >= MEM_WORDS.
REQ-020 On error, the FSM SHALL go IDLE->RESP with no memory access, so mem_we stays 0.
REQ-021 Load path: IDLE->LOAD->RESP. In LOAD, mem_we=0 and mem_addr is driven; the selected data is captured at the end of LOAD.
REQ-022 Load latency: resp_valid is high in the second cycle after the accept edge.
REQ-023 Load lane select (little-endian): byte k = mem_rdata[8k+7:8k] with k=addr[1:0]; halfword = mem_rdata[16h+15:16h] with h=addr[1].
REQ-024 Load extension: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
REQ-025 SW path: IDLE->STORE->RESP. mem_we=1 for exactly the STORE cycle, with mem_wdata=req_wdata.
REQ-026 SB/SH path: IDLE->RMW_RD->STORE->RESP. RMW_RD reads the old word with mem_we=0 and captures it. STORE writes the merged word: the addressed byte/halfword is replaced by req_wdata[7:0]/[15:0] and the other lanes are unchanged.
REQ-027 Store responses SHALL have resp_err=0 and resp_rdata=0.
REQ-028 RESP lasts exactly one cycle with resp_valid=1, then returns to IDLE.
REQ-029 req_ready=0 in RESP, so back-to-back requests are spaced by at least one RESP cycle.
REQ-030 mem_we SHALL be 1 only in STORE.
REQ-031 mem_addr and mem_wdata SHALL be stable across all cycles of an operation, and 0 in IDLE.
REQ-032 resp_valid, resp_rdata and resp_err SHALL be 0 outside RESP.

Reset
REQ-033 reset=0 SHALL immediately, without a clock, force: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; mem_we=0, mem_addr=0, mem_wdata=0; all captured registers=0.
REQ-034 Reset asserted mid-operation (LOAD/RMW_RD/STORE/RESP) SHALL abort with no response. Reset during STORE SHALL deassert mem_we asynchronously.
REQ-035 After reset release, req_ready=1 and the first request may be accepted on the next rising edge.

Verification
REQ-036 Memory word 5 = 0x80F1_7F22. LB at addr 0x16 -> resp_rdata=0xFFFF_FFF1 at accept+2. LBU at 0x16 -> 0x0000_00F1. LH at 0x16 -> 0xFFFF_80F1. LW at 0x14 -> 0x80F1_7F22.
REQ-037 Memory word 2 = 0x1122_3344. SB at addr 0x09 with wdata 0xAAAA_AA5A -> word 2 = 0x1122_5A44. mem_we=1 for exactly one cycle; resp_valid high at accept+3.
REQ-038 SW at 0x0C with wdata 0xDEAD_BEEF -> mem_we pulse in cycle accept+1, word 3 = 0xDEAD_BEEF, resp_valid at accept+2, resp_err=0.
REQ-039 Error cases, each -> resp_valid=1 and resp_err=1 at accept+1, mem_we never asserted, memory unchanged:
- LW at 0x06 (misaligned);
- LH at 0x03 (misaligned);
- SW at 0x1000 with MEM_WORDS=1024 (out of range);
- load funct3=011 (illegal).
REQ-040 Reset asserted during STORE of SB to word 7 -> mem_we drops to 0 immediately, no resp_valid, word 7 unchanged, req_ready=1 after release.
REQ-041 req_valid held high continuously with alternating LW and SW requests -> each accepted only when req_ready=1, exactly one resp_valid per accept, responses in request order.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: registers one CPU data request, checks it, and runs
// LB/LH/LW/LBU/LHU or SB/SH/SW against a word-wide memory (RMW for SB/SH).
// Ports: clk, reset (async, active-low), req_* request handshake,
//        resp_* one-cycle completion, mem_* word-indexed memory port.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] STORE  = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    localparam logic [31:0] WORDS = 32'(MEM_WORDS);

    logic [2:0]  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        bad_f3;
    logic        misalign;
    logic        out_range;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        busy;

    // Request checks operate on the live inputs, since they are
    // evaluated at the accept edge together with the field capture.
    always_comb begin
        if (req_we)
            bad_f3 = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            bad_f3 = req_funct3[1] & (req_funct3[0] | req_funct3[2]);
        misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                 | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        out_range = {2'b00, req_addr[31:2]} >= WORDS;
        req_err = bad_f3 | misalign | out_range;
    end

    always_comb begin
        byte_sel = 8'h00;
        unique case (addr_q[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_val = mem_rdata;
        case (f3_q)
            3'b000: load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001: load_val = {{16{half_sel[15]}}, half_sel};
            3'b100: load_val = {24'h0, byte_sel};
            3'b101: load_val = {16'h0, half_sel};
            default: load_val = mem_rdata;
        endcase

        // Sub-word store: replace only the addressed lane of the old word.
        merged = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (addr_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                        if (req_err)
                            state <= RESP;
                        else if (!req_we)
                            state <= LOAD;
                        else if (req_funct3[1:0] == 2'b10)
                            state <= STORE;
                        else
                            state <= RMW_RD;
                    end
                end
                LOAD: begin
                    rdata_q <= load_val;
                    state   <= RESP;
                end
                RMW_RD: begin
                    wdata_q <= merged;
                    state   <= STORE;
                end
                STORE: state <= RESP;
                RESP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = state != IDLE;
    assign req_ready  = state == IDLE;
    assign mem_addr   = busy ? {2'b00, addr_q[31:2]} : 32'h0;
    assign mem_wdata  = busy ? wdata_q : 32'h0;
    assign mem_we     = state == STORE;
    assign resp_valid = state == RESP;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
// Ports: drives all DUT inputs, models memory on mem_* signals.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

    // Issue one request, then scramble the inputs to prove they were
    // registered. Observes each later cycle at the falling edge.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic er, output int wes, output int we_at,
                          output logic [31:0] wa, output logic [31:0] wdat);
        lat = 0; rd = 0; er = 0; wes = 0; we_at = 0; wa = 0; wdat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_we) begin
                wes++;
                if (we_at == 0) begin
                    we_at = n; wa = mem_addr; wdat = mem_wdata;
                end
            end
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: ready=%b rv=%b we=%b need 1 0 0", req_ready, resp_valid, mem_we);
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h wd=%h rd=%h err=%b need 0", mem_addr, mem_wdata, resp_rdata, resp_err);
        end
        @(negedge clk);
        reset = 1'b1;
        // Async abort of a load in flight.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if (mem_addr !== 32'h5 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL load_busy: addr=%h ready=%b need 5 0", mem_addr, req_ready);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (mem_addr !== 32'h0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_abort: addr=%h ready=%b need 0 1", mem_addr, req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_noresp: rv=%b need 0", resp_valid);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [6];
        logic [31:0] ads [6];
        logic [31:0] exp [6];
        int lat, wes, we_at;
        logic [31:0] rd, wa, wdat;
        logic er;
        f3s = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b000};
        ads = '{32'h16, 32'h16, 32'h16, 32'h14, 32'h14, 32'h17};
        exp = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_80F1,
                32'h80F1_7F22, 32'h0000_7F22, 32'hFFFF_FF80};
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0, lat, rd, er, wes, we_at, wa, wdat);
            vectors++;
            if (lat !== 2 || rd !== exp[i] || er !== 1'b0 || wes !== 0) begin
                miscompares++;
                $display("FAIL load_%0d: lat=%0d rd=%h err=%b we=%0d need 2 %h 0 0",
                         i, lat, rd, er, wes, exp[i]);
            end
        end
        do_req(1'b0, 3'b010, 32'hFFC, 32'h0, lat, rd, er, wes, we_at, wa, wdat);
        vectors++;
        if (lat !== 2 || rd !== 32'hCAFE_0001 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL load_last_word: lat=%0d rd=%h err=%b need 2 cafe0001 0", lat, rd, er);
        end
    endtask

    task automatic test_sub_store;
        int lat, wes, we_at;
        logic [31:0] rd, wa, wdat;
        logic er;
        do_req(1'b1, 3'b000, 32'h09, 32'hAAAA_AA5A, lat, rd, er, wes, we_at, wa, wdat);
        vectors++;
        if (lat !== 3 || wes !== 1 || we_at !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_timing: lat=%0d we=%0d at=%0d rd=%h err=%b need 3 1 2 0 0",
                     lat, wes, we_at, rd, er);
        end
        vectors++;
        if (mem[2] !== 32'h1122_5A44) begin
            miscompares++;
            $display("FAIL sb_merge: word2=%h need 11225a44", mem[2]);
        end
        do_req(1'b1, 3'b001, 32'h0A, 32'h1234_BEEF, lat, rd, er, wes, we_at, wa, wdat);
        vectors++;
        if (lat !== 3 || wes !== 1 || mem[2] !== 32'hBEEF_5A44) begin
            miscompares++;
            $display("FAIL sh_merge: lat=%0d we=%0d word2=%h need 3 1 beef5a44", lat, wes, mem[2]);
        end
    endtask

    task automatic test_sw;
        int lat, wes, we_at;
        logic [31:0] rd, wa, wdat;
        logic er;
        do_req(1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, lat, rd, er, wes, we_at, wa, wdat);
        vectors++;
        if (lat !== 2 || wes !== 1 || we_at !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL sw_timing: lat=%0d we=%0d at=%0d err=%b rd=%h need 2 1 1 0 0",
                     lat, wes, we_at, er, rd);
        end
        vectors++;
        if (wa !== 32'h3 || wdat !== 32'hDEAD_BEEF || mem[3] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL sw_data: addr=%h wd=%h word3=%h need 3 deadbeef deadbeef", wa, wdat, mem[3]);
        end
        @(negedge clk);
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_outs: addr=%h wd=%h ready=%b need 0 0 1", mem_addr, mem_wdata, req_ready);
        end
    endtask

    task automatic test_errors;
        logic        wes_v [4];
        logic [2:0]  f3s [4];
        logic [31:0] ads [4];
        int lat, wes, we_at;
        logic [31:0] rd, wa, wdat;
        logic er;
        wes_v = '{1'b0, 1'b0, 1'b1, 1'b0};
        f3s   = '{3'b010, 3'b001, 3'b010, 3'b011};
        ads   = '{32'h06, 32'h03, 32'h1000, 32'h14};
        for (int i = 0; i < 4; i++) begin
            do_req(wes_v[i], f3s[i], ads[i], 32'h7777_7777, lat, rd, er, wes, we_at, wa, wdat);
            vectors++;
            if (lat !== 1 || er !== 1'b1 || wes !== 0 || rd !== 32'h0) begin
                miscompares++;
                $display("FAIL err_%0d: lat=%0d err=%b we=%0d rd=%h need 1 1 0 0",
                         i, lat, er, wes, rd);
            end
        end
        vectors++;
        if (mem[0] !== 32'h0BAD_F00D || mem[1] !== 32'h0123_4567) begin
            miscompares++;
            $display("FAIL err_mem: w0=%h w1=%h need 0badf00d 01234567", mem[0], mem[1]);
        end
    endtask

    task automatic test_reset_in_store;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h1D; req_wdata = 32'h0000_00FF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_store_pre: we=%b need 1", mem_we);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (mem_we !== 1'b0 || resp_valid !== 1'b0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_store_async: we=%b rv=%b addr=%h need 0 0 0", mem_we, resp_valid, mem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_store_ready: ready=%b need 1", req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem[7] !== 32'h0102_0304 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_store_mem: word7=%h rv=%b need 01020304 0", mem[7], resp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic        wv [4];
        logic [31:0] wd [4];
        logic [31:0] exp [4];
        int idx, rsp;
        wv  = '{1'b1, 1'b0, 1'b1, 1'b0};
        wd  = '{32'hA5A5_0001, 32'h0, 32'h5A5A_0002, 32'h0};
        exp = '{32'h0, 32'hA5A5_0001, 32'h0, 32'h5A5A_0002};
        idx = 0; rsp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h28;
        req_we = wv[0]; req_wdata = wd[0];
        idx = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                vectors++;
                if (rsp >= 4 || resp_rdata !== exp[rsp] || resp_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_resp_%0d: rd=%h err=%b need %h 0",
                             rsp, resp_rdata, resp_err, exp[rsp % 4]);
                end
                rsp++;
            end
            if (req_ready) begin
                if (idx < 4) begin
                    req_we = wv[idx]; req_wdata = wd[idx];
                    idx++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (!req_valid && rsp >= 4) break;
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (rsp !== 4 || idx !== 4 || resp_valid !== 1'b0 || mem[10] !== 32'h5A5A_0002) begin
            miscompares++;
            $display("FAIL b2b_count: resp=%0d acc=%0d rv=%b word10=%h need 4 4 0 5a5a0002",
                     rsp, idx, resp_valid, mem[10]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]    = 32'h0BAD_F00D;
        mem[1]    = 32'h0123_4567;
        mem[2]    = 32'h1122_3344;
        mem[5]    = 32'h80F1_7F22;
        mem[7]    = 32'h0102_0304;
        mem[1023] = 32'hCAFE_0001;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        reset = 1'b0;

        test_reset;
        test_loads;
        test_sub_store;
        test_sw;
        test_errors;
        test_reset_in_store;
        test_back_to_back;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
